// File: rtl/jt12_acc_mix.sv
// Per-channel carrier accumulator and stereo mixer for the FM core.
// One time-multiplexed operator result per clock; frame = 4*CHANNELS slots.
module jt12_acc_mix #(
   parameter int CHANNELS = 6,
   parameter int OPW      = 9,
   parameter int OUTW     = 12
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        sync,
   input  logic [OPW-1:0]              op_result,
   input  logic [2:0]                  alg,
   input  logic [1:0]                  rl,
   input  logic                        limiter_en,
   input  logic                        pcm_en,
   input  logic [OPW-1:0]              pcm,
   input  logic [CHANNELS-1:0]         ch_mute,
   output logic [OUTW-1:0]             left,
   output logic [OUTW-1:0]             right,
   output logic                        sample,
   output logic                        clip,
   output logic [OPW-1:0]              mux_left,
   output logic [OPW-1:0]              mux_right,
   output logic [$clog2(CHANNELS)-1:0] mux_ch,
   output logic                        mux_sample
);
   localparam int CHW = $clog2(CHANNELS);
   localparam int MW  = OPW + CHW + 1;
   localparam int SW  = ((MW > OUTW) ? MW : OUTW) + 1;
   localparam logic [CHW-1:0] LAST_CH = CHW'(CHANNELS-1);

   logic [CHW-1:0] ch_q, ch_cur;
   logic [1:0]     op_q, op_cur;
   logic           carrier;
   logic [OPW-1:0] acc [CHANNELS];
   logic [OPW-1:0] contrib, base, acc_nx, fin, gl, gr;
   logic [OPW:0]   sum_x;
   logic [MW-1:0]  mix_l, mix_r, mix_l_nx, mix_r_nx;
   logic [OUTW:0]  sat_l, sat_r;

   // {clipped, value}: clamp a wide signed sum into OUTW bits
   function automatic logic [OUTW:0] sat(input logic [SW-1:0] v);
      logic [SW-OUTW:0] hi;
      hi = v[SW-1:OUTW-1];
      if (hi == '0 || hi == '1) sat = {1'b0, v[OUTW-1:0]};
      else                      sat = {1'b1, v[SW-1], {(OUTW-1){~v[SW-1]}}};
   endfunction

   // sync overrides the slot for the current cycle only
   always_comb begin
      ch_cur = sync ? '0 : ch_q;
      op_cur = sync ? '0 : op_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ch_q <= '0;
         op_q <= '0;
      end else if (ch_cur == LAST_CH) begin
         ch_q <= '0;
         op_q <= op_cur + 2'd1;
      end else begin
         ch_q <= ch_cur + CHW'(1);
         op_q <= op_cur;
      end
   end

   always_comb begin
      case (op_cur)
         2'd0:    carrier = (alg == 3'd7);
         2'd1:    carrier = (alg >= 3'd4);
         2'd2:    carrier = (alg >= 3'd5);
         default: carrier = 1'b1;
      endcase
   end

   always_comb begin
      contrib = carrier ? op_result : '0;
      base    = (op_cur == 2'd0) ? '0 : acc[ch_cur];
      sum_x   = {base[OPW-1], base} + {contrib[OPW-1], contrib};
      if (limiter_en && (sum_x[OPW] != sum_x[OPW-1]))
         acc_nx = sum_x[OPW] ? {1'b1, {(OPW-1){1'b0}}} : {1'b0, {(OPW-1){1'b1}}};
      else
         acc_nx = sum_x[OPW-1:0];
      fin = acc_nx;
      if (pcm_en && ch_cur == LAST_CH) fin = {~pcm[OPW-1], pcm[OPW-2:0]};
      if (ch_mute[ch_cur])             fin = '0;
      gl = rl[1] ? fin : '0;
      gr = rl[0] ? fin : '0;
      mix_l_nx = {{(MW-OPW){gl[OPW-1]}}, gl};
      mix_r_nx = {{(MW-OPW){gr[OPW-1]}}, gr};
      if (ch_cur != '0) begin
         mix_l_nx = mix_l + mix_l_nx;
         mix_r_nx = mix_r + mix_r_nx;
      end
      sat_l = sat({{(SW-MW){mix_l_nx[MW-1]}}, mix_l_nx});
      sat_r = sat({{(SW-MW){mix_r_nx[MW-1]}}, mix_r_nx});
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < CHANNELS; i++) acc[i] <= '0;
         mix_l      <= '0;
         mix_r      <= '0;
         left       <= '0;
         right      <= '0;
         sample     <= 1'b0;
         clip       <= 1'b0;
         mux_left   <= '0;
         mux_right  <= '0;
         mux_ch     <= '0;
         mux_sample <= 1'b0;
      end else begin
         sample         <= 1'b0;
         clip           <= 1'b0;
         mux_sample     <= 1'b0;
         acc[ch_cur]    <= acc_nx;
         if (op_cur == 2'd3) begin
            mux_ch     <= ch_cur;
            mux_left   <= gl;
            mux_right  <= gr;
            mux_sample <= 1'b1;
            mix_l      <= mix_l_nx;
            mix_r      <= mix_r_nx;
            if (ch_cur == LAST_CH) begin
               left   <= sat_l[OUTW-1:0];
               right  <= sat_r[OUTW-1:0];
               sample <= 1'b1;
               clip   <= sat_l[OUTW] | sat_r[OUTW];
            end
         end
      end
   end
endmodule

// File: tb/tb_jt12_acc_mix.sv
// Directed bench for jt12_acc_mix: default instance plus an OUTW=10 instance.
module tb_jt12_acc_mix;
   localparam int CH = 6;
   localparam int OPW = 9;

   logic clk = 1'b0, rst = 1'b1, sync = 1'b0, limiter_en = 1'b1, pcm_en = 1'b0;
   logic [OPW-1:0] op_result = '0, pcm = '0;
   logic [2:0] alg = '0;
   logic [1:0] rl = '0;
   logic [CH-1:0] ch_mute = '0;

   logic [11:0] left0, right0;
   logic [9:0]  left1, right1;
   logic sample0, clip0, mux_sample0, sample1, clip1, mux_sample1;
   logic [OPW-1:0] mux_left0, mux_right0, mux_left1, mux_right1;
   logic [2:0] mux_ch0, mux_ch1;

   jt12_acc_mix #(.CHANNELS(CH), .OPW(OPW), .OUTW(12)) u0 (
      .clk(clk), .rst(rst), .sync(sync), .op_result(op_result), .alg(alg), .rl(rl),
      .limiter_en(limiter_en), .pcm_en(pcm_en), .pcm(pcm), .ch_mute(ch_mute),
      .left(left0), .right(right0), .sample(sample0), .clip(clip0),
      .mux_left(mux_left0), .mux_right(mux_right0), .mux_ch(mux_ch0), .mux_sample(mux_sample0));

   jt12_acc_mix #(.CHANNELS(CH), .OPW(OPW), .OUTW(10)) u1 (
      .clk(clk), .rst(rst), .sync(sync), .op_result(op_result), .alg(alg), .rl(rl),
      .limiter_en(limiter_en), .pcm_en(pcm_en), .pcm(pcm), .ch_mute(ch_mute),
      .left(left1), .right(right1), .sample(sample1), .clip(clip1),
      .mux_left(mux_left1), .mux_right(mux_right1), .mux_ch(mux_ch1), .mux_sample(mux_sample1));

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]          alg;
      logic [3:0][OPW-1:0] ops;
      logic [1:0]          rl;
      logic                lim, pen;
      logic [OPW-1:0]      pcm;
      logic [CH-1:0]       mute;
      int exch, ex5, l0, r0, l1, r1, c0, c1;
   } vec_t;

   vec_t vecs[11];
   int pass_cnt = 0, total = 0;

   function automatic vec_t mk(input int a, o1, o2, o3, o4, r, lim, pen, pc, mute,
                               exch, ex5, l0, r0, l1, r1, c0, c1);
      vec_t v;
      v.alg = 3'(a);
      v.ops = {OPW'(o4), OPW'(o3), OPW'(o2), OPW'(o1)};
      v.rl = 2'(r); v.lim = 1'(lim); v.pen = 1'(pen); v.pcm = OPW'(pc); v.mute = CH'(mute);
      v.exch = exch; v.ex5 = ex5; v.l0 = l0; v.r0 = r0; v.l1 = l1; v.r1 = r1;
      v.c0 = c0; v.c1 = c1;
      return v;
   endfunction

   function automatic int exp_ch(input vec_t v, input int c);
      if (c < 0 || c >= CH) return -9999;
      if (v.mute[c]) return 0;
      return (c == CH-1) ? v.ex5 : v.exch;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic apply(input vec_t v);
      alg = v.alg; rl = v.rl; limiter_en = v.lim; pcm_en = v.pen; pcm = v.pcm; ch_mute = v.mute;
   endtask

   task automatic partial(input vec_t v, input int n, input string tag);
      bit early;
      early = 0;
      apply(v);
      for (int k = 0; k < n; k++) begin
         sync = (k == 0);
         op_result = v.ops[k / CH];
         @(posedge clk); #1;
         if (sample0 || sample1) early = 1;
      end
      sync = 0;
      chk({tag, " no sample"}, early, 0);
   endtask

   task automatic run_frame(input vec_t v, input bit use_sync, input string tag);
      bit early;
      int seen;
      early = 0; seen = 0;
      apply(v);
      for (int k = 0; k < 4*CH; k++) begin
         sync = use_sync && (k == 0);
         op_result = v.ops[k / CH];
         @(posedge clk); #1;
         if (mux_sample0) begin
            int c, e;
            c = k - 3*CH;
            e = exp_ch(v, c);
            chk({tag, " mux_ch"}, int'(mux_ch0), c);
            chk({tag, " mux_left"}, int'($signed(mux_left0)), v.rl[1] ? e : 0);
            chk({tag, " mux_right"}, int'($signed(mux_right0)), v.rl[0] ? e : 0);
            seen++;
         end
         if (k < 4*CH-1 && (sample0 || sample1)) early = 1;
      end
      sync = 0;
      chk({tag, " early sample"}, early, 0);
      chk({tag, " mux count"}, seen, CH);
      chk({tag, " sample0"}, sample0, 1);
      chk({tag, " sample1"}, sample1, 1);
      chk({tag, " left12"}, int'($signed(left0)), v.l0);
      chk({tag, " right12"}, int'($signed(right0)), v.r0);
      chk({tag, " left10"}, int'($signed(left1)), v.l1);
      chk({tag, " right10"}, int'($signed(right1)), v.r1);
      chk({tag, " clip12"}, clip0, v.c0);
      chk({tag, " clip10"}, clip1, v.c1);
   endtask

   initial begin
      //            alg o1   o2  o3  o4  rl lim pen pcm    mute     ch    ch5   l0     r0     l1    r1   c0 c1
      vecs[0]  = mk(7, 10,  10, 10, 10, 3, 1, 0, 0,     0,       40,   40,   240,   240,   240,  240, 0, 0);
      vecs[1]  = mk(4, 5,   7,  11, 13, 2, 1, 0, 0,     0,       20,   20,   120,   0,     120,  0,   0, 0);
      vecs[2]  = mk(7, 200, 200,200,200,3, 1, 0, 0,     0,       255,  255,  1530,  1530,  511,  511, 0, 1);
      vecs[3]  = mk(7, 200, 200,200,200,3, 0, 0, 0,     0,       -224, -224, -1344, -1344, -512, -512,0, 1);
      vecs[4]  = mk(7, 10,  10, 10, 10, 3, 1, 1, 0,     0,       40,   -256, -56,   -56,   -56,  -56, 0, 0);
      vecs[5]  = mk(7, 10,  10, 10, 10, 3, 1, 1, 'h1FF, 0,       40,   255,  455,   455,   455,  455, 0, 0);
      vecs[6]  = mk(7, 10,  10, 10, 10, 3, 1, 1, 'h1FF, 'b100000,40,   0,    200,   200,   200,  200, 0, 0);
      vecs[7]  = mk(7, -64, -64,-64,-64,3, 1, 0, 0,     0,       -256, -256, -1536, -1536, -512, -512,0, 1);
      vecs[8]  = mk(0, 1,   2,  3,  50, 1, 1, 0, 0,     0,       50,   50,   0,     300,   0,    300, 0, 0);
      vecs[9]  = mk(5, 100, 1,  2,  3,  3, 1, 0, 0,     'b000011,6,    6,    24,    24,    24,   24,  0, 0);
      vecs[10] = mk(6, 100, 1,  2,  3,  3, 1, 0, 0,     0,       6,    6,    36,    36,    36,   36,  0, 0);

      repeat (2) @(posedge clk);
      #1;
      chk("rst left", int'(left0), 0);
      chk("rst sample", sample0, 0);
      chk("rst mux_sample", mux_sample0, 0);
      chk("rst clip", clip1, 0);
      rst = 1'b0;

      for (int i = 0; i < 11; i++) run_frame(vecs[i], 1'b1, $sformatf("v%0d", i));

      // frame cut short by sync at slot 10, then a clean frame
      partial(vecs[0], 10, "trunc10");
      run_frame(vecs[1], 1'b1, "after_trunc10");
      // sync landing on what would have been the last slot
      partial(vecs[0], 23, "trunc23");
      run_frame(vecs[2], 1'b1, "after_trunc23");

      // asynchronous reset mid-frame, then free-running count from slot 0
      run_frame(vecs[0], 1'b1, "pre_rst");
      partial(vecs[0], 12, "mid");
      #1 rst = 1'b1;
      #1;
      chk("async left", int'(left0), 0);
      chk("async right", int'(right1), 0);
      chk("async mux_left", int'(mux_left0), 0);
      chk("async mux_sample", mux_sample0, 0);
      #1 rst = 1'b0;
      run_frame(vecs[8], 1'b0, "post_rst");

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end
endmodule
